// File: rtl/pq_traffic_checker.sv
// LFSR-driven fill/replace/drain traffic generator for a priority queue, self-checked
// against a sorted shadow copy of the expected queue contents.
module pq_traffic_checker #(
  parameter int unsigned KEY_WIDTH = 8,
  parameter int unsigned VAL_WIDTH = 8,
  parameter int unsigned DEPTH     = 15,
  parameter int unsigned N_REPLACE = 15,
  parameter int unsigned SPACE     = 4,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           enq,
  output logic                           deq,
  output logic [KEY_WIDTH+VAL_WIDTH-1:0] kvi,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0] kvo,
  input  logic                           empty,
  input  logic                           full,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [15:0]                    err_count,
  output logic [15:0]                    op_count,
  output logic [KEY_WIDTH-1:0]           first_err_key
);

  localparam int unsigned KV_WIDTH    = KEY_WIDTH + VAL_WIDTH;
  localparam int unsigned CNT_WIDTH   = $clog2(DEPTH + 1);
  localparam int unsigned WAIT_WIDTH  = (SPACE > 0) ? $clog2(SPACE + 1) : 1;
  localparam int unsigned PHASE_MAX   = (DEPTH > N_REPLACE) ? DEPTH : N_REPLACE;
  localparam int unsigned PHASE_WIDTH = $clog2(PHASE_MAX + 1);

  typedef enum logic [2:0] {IDLE, FILL, REPLACE, DRAIN, FINAL, DONE} state_t;

  state_t                 state;
  logic [WAIT_WIDTH-1:0]  wait_cnt;
  logic [PHASE_WIDTH-1:0] phase_cnt;
  logic [15:0]            lfsr;
  logic [KEY_WIDTH-1:0]   model [DEPTH];
  logic [CNT_WIDTH-1:0]   model_cnt;
  logic                   key_err_seen;

  logic [15:0]            lfsr_next;
  logic [KEY_WIDTH-1:0]   new_key;
  logic                   in_op, issue, is_enq, is_deq, sample, phase_last;
  state_t                 phase_next;
  logic                   empty_err, full_err, key_err;
  logic [17:0]            err_total;
  logic [15:0]            err_sum;
  logic [KEY_WIDTH-1:0]   base [DEPTH];
  logic [CNT_WIDTH-1:0]   base_cnt;
  logic [KEY_WIDTH-1:0]   model_nxt [DEPTH];
  logic [CNT_WIDTH-1:0]   model_cnt_nxt;
  logic [CNT_WIDTH-1:0]   ins_pos;
  logic                   unused_val;

  // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form)
  assign lfsr_next  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign new_key    = lfsr_next[KEY_WIDTH-1:0];
  assign unused_val = ^kvo[VAL_WIDTH-1:0];

  // Issue/sample qualification and phase sequencing
  always_comb begin
    in_op      = (state == FILL) || (state == REPLACE) || (state == DRAIN);
    issue      = in_op && (wait_cnt == '0);
    is_enq     = issue && (state != DRAIN);
    is_deq     = issue && (state != FILL);
    sample     = issue || ((state == FINAL) && (wait_cnt == '0));
    phase_last = 1'b0;
    phase_next = FINAL;
    case (state)
      FILL: begin
        phase_last = (phase_cnt == PHASE_WIDTH'(DEPTH - 1));
        phase_next = (N_REPLACE == 0) ? DRAIN : REPLACE;
      end
      REPLACE: begin
        phase_last = (phase_cnt == PHASE_WIDTH'(N_REPLACE - 1));
        phase_next = DRAIN;
      end
      DRAIN: begin
        phase_last = (phase_cnt == PHASE_WIDTH'(DEPTH - 1));
        phase_next = FINAL;
      end
      default: ;
    endcase
  end

  // Flag and head-key checks against the model state before this edge's update
  always_comb begin
    empty_err = sample && (empty != (model_cnt == '0));
    full_err  = sample && (full != (model_cnt == CNT_WIDTH'(DEPTH)));
    key_err   = is_deq && (kvo[KV_WIDTH-1 -: KEY_WIDTH] != model[0]);
    err_total = 18'(err_count) + 18'(empty_err) + 18'(full_err) + 18'(key_err);
    err_sum   = (err_total > 18'h0FFFF) ? 16'hFFFF : err_total[15:0];
  end

  // Shadow model: pop head first, then stable sorted insert (after equal keys)
  always_comb begin
    base     = model;
    base_cnt = model_cnt;
    if (is_deq && (model_cnt != '0)) begin
      for (int i = 0; i < DEPTH - 1; i++) base[i] = model[i+1];
      base[DEPTH-1] = '0;
      base_cnt      = model_cnt - CNT_WIDTH'(1);
    end
    model_nxt     = base;
    model_cnt_nxt = base_cnt;
    ins_pos       = '0;
    if (is_enq && (base_cnt != CNT_WIDTH'(DEPTH))) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_WIDTH'(i) < base_cnt) && (base[i] <= new_key)) ins_pos = ins_pos + CNT_WIDTH'(1);
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_WIDTH'(i) == ins_pos) model_nxt[i] = new_key;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (CNT_WIDTH'(i) > ins_pos) model_nxt[i] = base[i-1];
      end
      model_cnt_nxt = base_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      phase_cnt     <= '0;
      lfsr          <= SEED;
      model_cnt     <= '0;
      key_err_seen  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) model[i] <= '0;
      enq           <= 1'b0;
      deq           <= 1'b0;
      kvi           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      op_count      <= '0;
      first_err_key <= '0;
    end else begin
      enq <= 1'b0;
      deq <= 1'b0;
      if (sample) begin
        err_count <= err_sum;
        if (key_err && !key_err_seen) begin
          key_err_seen  <= 1'b1;
          first_err_key <= model[0];
        end
      end
      case (state)
        IDLE, DONE: begin
          busy <= 1'b0;
          done <= (state == DONE);
          pass <= (state == DONE) && (err_count == '0);
          if (start) begin
            state         <= FILL;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            op_count      <= '0;
            first_err_key <= '0;
            key_err_seen  <= 1'b0;
            model_cnt     <= '0;
            lfsr          <= SEED;
            wait_cnt      <= '0;
            phase_cnt     <= '0;
          end
        end
        FILL, REPLACE, DRAIN: begin
          busy <= 1'b1;
          if (issue) begin
            enq       <= is_enq;
            deq       <= is_deq;
            op_count  <= op_count + 16'd1;
            model     <= model_nxt;
            model_cnt <= model_cnt_nxt;
            wait_cnt  <= WAIT_WIDTH'(SPACE);
            if (is_enq) begin
              kvi  <= {new_key, op_count[VAL_WIDTH-1:0]};
              lfsr <= lfsr_next;
            end
            if (phase_last) begin
              phase_cnt <= '0;
              state     <= phase_next;
            end else begin
              phase_cnt <= phase_cnt + PHASE_WIDTH'(1);
            end
          end else begin
            wait_cnt <= wait_cnt - WAIT_WIDTH'(1);
          end
        end
        FINAL: begin
          if (wait_cnt == '0) state <= DONE;
          else wait_cnt <= wait_cnt - WAIT_WIDTH'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pq_traffic_checker.sv
// Bench for pq_traffic_checker: two checker instances, each driving a behavioural
// min-queue that settles on the falling edge; faults are injected into unit 0.
module tb_pq_traffic_checker;

  localparam int KW = 8;
  localparam int VW = 8;
  localparam int KV = KW + VW;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] start;
  logic [1:0] empty, full;
  logic [KV-1:0] kvo [2];
  wire  [1:0] enq, deq, busy, done, pass;
  wire  [KV-1:0] kvi [2];
  wire  [15:0] err_count [2];
  wire  [15:0] op_count [2];
  wire  [KW-1:0] first_err_key [2];

  always #5 clk = ~clk;

  pq_traffic_checker #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .DEPTH(15), .N_REPLACE(15),
                       .SPACE(4), .SEED(16'hACE1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .enq(enq[0]), .deq(deq[0]),
    .kvi(kvi[0]), .kvo(kvo[0]), .empty(empty[0]), .full(full[0]), .busy(busy[0]),
    .done(done[0]), .pass(pass[0]), .err_count(err_count[0]), .op_count(op_count[0]),
    .first_err_key(first_err_key[0])
  );

  pq_traffic_checker #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .DEPTH(15), .N_REPLACE(0),
                       .SPACE(0), .SEED(16'hACE1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .enq(enq[1]), .deq(deq[1]),
    .kvi(kvi[1]), .kvo(kvo[1]), .empty(empty[1]), .full(full[1]), .busy(busy[1]),
    .done(done[1]), .pass(pass[1]), .err_count(err_count[1]), .op_count(op_count[1]),
    .first_err_key(first_err_key[1])
  );

  // Behavioural PQ: unsorted store, head = smallest key
  logic [KV-1:0] st [2][16];
  int            cnt [2];
  int            drain_n [2];
  int            m_i;
  logic [KV-1:0] hd;
  logic          stuck_empty, fault_key;
  logic [KW-1:0] exp_fek;

  function automatic int min_idx(input int u);
    int m = 0;
    for (int i = 1; i < cnt[u]; i++)
      if (st[u][i][KV-1 -: KW] < st[u][m][KV-1 -: KW]) m = i;
    return m;
  endfunction

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        cnt[u]     = 0;
        drain_n[u] = 0;
      end else begin
        if (enq[u] && !deq[u] && cnt[u] == 0) drain_n[u] = 0;
        if (deq[u] && cnt[u] > 0) begin
          m_i = min_idx(u);
          for (int i = m_i; i < cnt[u] - 1; i++) st[u][i] = st[u][i+1];
          cnt[u] = cnt[u] - 1;
          if (!enq[u]) drain_n[u] = drain_n[u] + 1;
        end
        if (enq[u] && cnt[u] < 16) begin
          st[u][cnt[u]] = kvi[u];
          cnt[u] = cnt[u] + 1;
        end
      end
      hd = (cnt[u] > 0) ? st[u][min_idx(u)] : '0;
      if (u == 0 && fault_key && drain_n[u] == 2) begin
        exp_fek = hd[KV-1 -: KW];
        hd = {hd[KV-1 -: KW] + 8'd1, hd[VW-1:0]};
      end
      kvo[u]   <= hd;
      empty[u] <= (cnt[u] == 0) || (u == 0 && stuck_empty);
      full[u]  <= (cnt[u] == 15);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int            edge_n, done_edge, enq_seen, first_enq_edge;
  logic [KV-1:0] cap [3];
  logic          busy_mid;

  // Start unit u (start sampled at edge 0), track edges until done or abort_at
  task automatic run(input int u, input int poke_at, input int abort_at);
    @(negedge clk); start[u] = 1'b1;
    @(negedge clk); start[u] = 1'b0;
    edge_n = 0; enq_seen = 0; done_edge = -1; first_enq_edge = -1; busy_mid = 1'b0;
    while (edge_n < 3000) begin
      @(negedge clk);
      edge_n++;
      if (enq[u]) begin
        if (enq_seen == 0) first_enq_edge = edge_n;
        if (enq_seen < 3) cap[enq_seen] = kvi[u];
        enq_seen++;
      end
      if (edge_n == 20) busy_mid = busy[u];
      if (done[u]) begin
        done_edge = edge_n;
        break;
      end
      start[u] = (edge_n == poke_at);
      if (edge_n == abort_at) break;
    end
    start[u] = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_strobes"}, {27'd0, enq[0], deq[0], busy[0], done[0], pass[0]}, 32'd0);
    check_eq({tag, "_kvi"}, 32'(kvi[0]), 32'd0);
    check_eq({tag, "_err"}, 32'(err_count[0]), 32'd0);
    check_eq({tag, "_ops"}, 32'(op_count[0]), 32'd0);
    check_eq({tag, "_fek"}, 32'(first_err_key[0]), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 2'b00; stuck_empty = 1'b0; fault_key = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    check_eq("reset_u1", {27'd0, enq[1], deq[1], busy[1], done[1], pass[1]}, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("idle_no_strobe", {30'd0, enq[0], deq[0]}, 32'd0);

    // Ideal run with defaults; a start pulse during FILL must be ignored
    run(0, 10, -1);
    check_eq("ideal_first_enq_edge", 32'(first_enq_edge), 32'd1);
    check_eq("ideal_kvi0", 32'(cap[0]), 32'h7000);
    check_eq("ideal_kvi1", 32'(cap[1]), 32'h3801);
    check_eq("ideal_kvi2", 32'(cap[2]), 32'h9C02);
    check_eq("ideal_busy_mid", 32'(busy_mid), 32'd1);
    check_eq("ideal_done_edge", 32'(done_edge), 32'd227);
    check_eq("ideal_ops", 32'(op_count[0]), 32'd45);
    check_eq("ideal_err", 32'(err_count[0]), 32'd0);
    check_eq("ideal_pass", 32'(pass[0]), 32'd1);
    check_eq("ideal_busy_end", 32'(busy[0]), 32'd0);
    check_eq("ideal_fek", 32'(first_err_key[0]), 32'd0);
    @(negedge clk);
    check_eq("done_held", 32'(done[0]), 32'd1);

    // Wrong key on the third DRAIN dequeue
    fault_key = 1'b1;
    run(0, -1, -1);
    fault_key = 1'b0;
    check_eq("fkey_done_edge", 32'(done_edge), 32'd227);
    check_eq("fkey_err", 32'(err_count[0]), 32'd1);
    check_eq("fkey_first_err_key", 32'(first_err_key[0]), 32'(exp_fek));
    check_eq("fkey_pass", 32'(pass[0]), 32'd0);

    // empty stuck at 1
    stuck_empty = 1'b1;
    run(0, -1, -1);
    stuck_empty = 1'b0;
    check_eq("stuck_err", 32'(err_count[0]), 32'd44);
    check_eq("stuck_pass", 32'(pass[0]), 32'd0);
    check_eq("stuck_fek", 32'(first_err_key[0]), 32'd0);

    // Back-to-back, no REPLACE phase
    run(1, -1, -1);
    check_eq("b2b_first_enq_edge", 32'(first_enq_edge), 32'd1);
    check_eq("b2b_kvi0", 32'(cap[0]), 32'h7000);
    check_eq("b2b_done_edge", 32'(done_edge), 32'd32);
    check_eq("b2b_ops", 32'(op_count[1]), 32'd30);
    check_eq("b2b_err", 32'(err_count[1]), 32'd0);
    check_eq("b2b_pass", 32'(pass[1]), 32'd1);

    // Reset in the middle of REPLACE, then a clean rerun
    run(0, -1, 100);
    check_eq("abort_busy", 32'(busy[0]), 32'd1);
    #2 rst = 1'b1;
    #1 check_idle_outputs("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("midrst_no_strobe", {30'd0, enq[0], deq[0]}, 32'd0);
    run(0, -1, -1);
    check_eq("rerun_kvi0", 32'(cap[0]), 32'h7000);
    check_eq("rerun_kvi1", 32'(cap[1]), 32'h3801);
    check_eq("rerun_done_edge", 32'(done_edge), 32'd227);
    check_eq("rerun_ops", 32'(op_count[0]), 32'd45);
    check_eq("rerun_pass", 32'(pass[0]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pq_traffic_checker.md
# pq_traffic_checker

Synthesizable, parametrised stimulus generator and self-checker for any priority-queue implementation on the team's PQ port (enq/deq/kvi/kvo/empty/full). It replaces hand-written fixed sequences such as fill-15 / replace-15 / drain with an LFSR-driven run of configurable depth, operation spacing and replace count. A sorted shadow register array serves as the golden model. It sits beside the DUT in every PQ top (register array, pipelined heap, systolic), and can also run on FPGA with `pass`/`err_count` brought to LEDs.

## Interface
- KEY_WIDTH, 8, key field width; kvi/kvo = {key,val}
- VAL_WIDTH, 8, value field width
- DEPTH, 15, DUT capacity; number of fill enqueues and of drain dequeues
- N_REPLACE, 15, number of enq+deq (replace) operations; 0 skips REPLACE
- SPACE, 4, idle cycles after every issued operation (0 = back-to-back)
- SEED, 16'hACE1, LFSR reset/restart value (nonzero)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run when in IDLE or DONE
- enq  out  1  enqueue strobe to DUT
- deq  out  1  dequeue strobe to DUT
- kvi  out  KEY_WIDTH+VAL_WIDTH  key/value to DUT
- kvo  in  KEY_WIDTH+VAL_WIDTH  DUT head (highest priority = smallest key)
- empty  in  1  DUT empty flag
- full  in  1  DUT full flag
- busy  out  1  run in progress
- done  out  1  run finished; held until next start
- pass  out  1  done && err_count==0
- err_count  out  16  saturating error count
- op_count  out  16  operations issued this run
- first_err_key  out  KEY_WIDTH  expected key at first key mismatch, else 0

## Operation
- FSM states: IDLE, FILL, REPLACE, DRAIN, FINAL, DONE.
- IDLE/DONE + start: clear err_count, op_count, first_err_key and model; reload LFSR to SEED; go to FILL.
- FILL: issue DEPTH enqueues.
- REPLACE: issue N_REPLACE operations with enq=deq=1.
- DRAIN: issue DEPTH dequeues.
- FINAL: one sample of the flags, then DONE.
- Issue cycle: one-cycle strobe, then SPACE wait cycles counted by a wait counter. op_count increments on each issue.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances on each enq issue.
  - key = lfsr[KEY_WIDTH-1:0]
  - val = op_count[VAL_WIDTH-1:0]
- Model: DEPTH-entry ascending-sorted register array plus count.
  - Enq inserts in sorted position; equal keys go after existing equal keys.
  - Deq removes entry 0.
  - Replace removes the head, then inserts the new key, in the same cycle.
- Checks, sampled at each issue edge and at FINAL:
  - empty must equal (count==0).
  - full must equal (count==DEPTH).
  - On every deq or replace issue, kvo key must equal model head key. Values are not compared (ties are unordered).
- Each failed check increments err_count by 1 (saturates at 16'hFFFF). Flag and key mismatches in the same cycle count separately.
- The first key mismatch latches first_err_key.
- start while busy is ignored.

## Timing
- Reset values, asserted asynchronously:
  - Outputs: enq=0, deq=0, kvi=0, busy=0, done=0, pass=0, err_count=0, op_count=0, first_err_key=0.
  - FSM in IDLE; LFSR=SEED; model count=0.
- start is sampled high at edge 0. The first issue (enq=1) is registered at edge 1.
- busy is 1 from edge 1 until DONE.
- Run length: Nops = 2*DEPTH+N_REPLACE. Issues occur at edges 1 + k*(SPACE+1), for k = 0..Nops-1.
- FINAL sample occurs SPACE+1 edges after the last issue. done and pass assert on the following edge.
- Outputs are registered. The model and checks update on the same edge the strobe is driven.
- Flags and kvo must be settled after SPACE idle cycles; the checker does not wait on them.
- Reset mid-run returns to IDLE with the reset values above. The next start reproduces the identical key sequence.

## Test plan
- Reset: assert rst mid-cycle -> all outputs 0 immediately; no strobes until start.
- Ideal behavioural PQ, defaults: start -> op_count=45, err_count=0, pass=1; done at edge 2+45*5=227. First three kvi keys are the low 8 bits of LFSR states 1-3 from 16'hACE1.
- Fault injection (wrong key): DUT returns head key+1 on the 3rd DRAIN dequeue -> err_count=1, first_err_key = the 3rd-smallest remaining expected key, pass=0.
- Stuck flag: empty tied to 1, kvo otherwise correct -> err_count=44 (14 FILL + 15 REPLACE + 15 DRAIN samples), pass=0.
- N_REPLACE=0, SPACE=0: ops issue every cycle; op_count=30; done at edge 32; ideal DUT -> pass=1.
- Control: start pulsed during FILL is ignored (op_count unaffected). rst during REPLACE, then start -> first kvi equals the first kvi of the original run.
